// File: rtl/qdi_chk_pkg.sv
// Shared types and constants for the QDI result checker.
//   chk_state_t : checker FSM states
//   DR_*        : dual-rail (1-of-2) channel encodings, [1]=true rail, [0]=false rail
package qdi_chk_pkg;

  typedef enum logic [1:0] {
    INIT,
    WAIT_DATA,
    CHECK,
    WAIT_NEUTRAL
  } chk_state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_F    = 2'b01;
  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

endpackage

// File: rtl/qdi_chk_fifo.sv
// Synchronous FIFO holding expected result tokens.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push     : write wdata when not full (ignored when full)
//   pop      : drop the head entry when not empty
//   rdata    : head entry (valid while !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
module qdi_chk_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qdi_result_checker.sv
// Clocked 4-phase receiver and scoreboard for the dual-rail Sum/Carry outputs
// of a QDI full adder.
//   CLK, RESET            : clock, asynchronous active-high reset
//   Sx, Co                : dual-rail sum / carry channels (00 = neutral)
//   Sxe, Coe              : channel enables (1 = ready for data, 0 = ack)
//   exp_valid/data/ready  : expected {co,sum} push interface
//   rx_valid, rx_data     : one-cycle pulse with decoded {co,sum} per token
//   match_cnt, miss_cnt   : saturating result counters
//   illegal_err           : sticky, a synced channel showed 11
//   timeout_err           : sticky, handshake stalled for TIMEOUT cycles
module qdi_result_checker
  import qdi_chk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       Sx,
  input  logic [1:0]       Co,
  output logic             Sxe,
  output logic             Coe,
  input  logic             exp_valid,
  input  logic [1:0]       exp_data,
  output logic             exp_ready,
  output logic             rx_valid,
  output logic [1:0]       rx_data,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             illegal_err,
  output logic             timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  // Synchronizer flops are deliberately not reset: they keep sampling the
  // rails during reset, so a token held across reset is still visible to INIT.
  logic [SYNC_STAGES-1:0][1:0] sx_pipe;
  logic [SYNC_STAGES-1:0][1:0] co_pipe;
  logic [1:0] sx_s;
  logic [1:0] co_s;

  always_ff @(posedge CLK) begin
    sx_pipe <= {sx_pipe[SYNC_STAGES-2:0], Sx};
    co_pipe <= {co_pipe[SYNC_STAGES-2:0], Co};
  end

  assign sx_s = sx_pipe[SYNC_STAGES-1];
  assign co_s = co_pipe[SYNC_STAGES-1];

  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_head;
  logic       pop;

  assign exp_ready = !fifo_full;

  qdi_chk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (exp_valid),
    .wdata (exp_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  chk_state_t state, state_next;
  logic sum_cap, co_cap, sum_v, co_v, ill;
  logic sum_cap_n, co_cap_n, sum_v_n, co_v_n, ill_n;
  logic sxe_n, coe_n;
  logic [TW-1:0] timer;
  logic count_en;
  logic all_null;
  logic is_match;

  assign all_null = (sx_s == DR_NULL) && (co_s == DR_NULL);
  assign count_en = ((state == WAIT_DATA) && !fifo_empty) || (state == WAIT_NEUTRAL);
  assign is_match = !ill && ({co_v, sum_v} == fifo_head);

  always_comb begin
    state_next = state;
    sum_cap_n  = sum_cap;
    co_cap_n   = co_cap;
    sum_v_n    = sum_v;
    co_v_n     = co_v;
    ill_n      = ill;
    pop        = 1'b0;
    unique case (state)
      INIT: begin
        if (all_null) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (!sum_cap && (sx_s != DR_NULL)) begin
          sum_cap_n = 1'b1;
          sum_v_n   = sx_s[1];
          if (sx_s == DR_ILL) ill_n = 1'b1;
        end
        if (!co_cap && (co_s != DR_NULL)) begin
          co_cap_n = 1'b1;
          co_v_n   = co_s[1];
          if (co_s == DR_ILL) ill_n = 1'b1;
        end
        if (sum_cap && co_cap && !fifo_empty) state_next = CHECK;
      end
      CHECK: begin
        pop        = 1'b1;
        state_next = WAIT_NEUTRAL;
      end
      WAIT_NEUTRAL: begin
        if (all_null) begin
          state_next = WAIT_DATA;
          sum_cap_n  = 1'b0;
          co_cap_n   = 1'b0;
          ill_n      = 1'b0;
        end
      end
      default: state_next = INIT;
    endcase
    // Enables are registered from next-state values so each one drops the
    // cycle after its own capture and both rise together on leaving WAIT_NEUTRAL.
    sxe_n = (state_next == WAIT_DATA) && !sum_cap_n;
    coe_n = (state_next == WAIT_DATA) && !co_cap_n;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= INIT;
      sum_cap     <= 1'b0;
      co_cap      <= 1'b0;
      sum_v       <= 1'b0;
      co_v        <= 1'b0;
      ill         <= 1'b0;
      Sxe         <= 1'b0;
      Coe         <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      illegal_err <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
    end else begin
      state    <= state_next;
      sum_cap  <= sum_cap_n;
      co_cap   <= co_cap_n;
      sum_v    <= sum_v_n;
      co_v     <= co_v_n;
      ill      <= ill_n;
      Sxe      <= sxe_n;
      Coe      <= coe_n;
      rx_valid <= (state_next == CHECK);
      if (state_next == CHECK) rx_data <= {co_v, sum_v};
      if (state == CHECK) begin
        if (is_match) begin
          if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if ((sx_s == DR_ILL) || (co_s == DR_ILL)) illegal_err <= 1'b1;
      if (state_next != state) begin
        timer <= '0;
      end else if (count_en && (timer != T_MAX)) begin
        timer <= timer + 1'b1;
      end
      if (timer == T_MAX) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qdi_result_checker.sv
module tb_qdi_result_checker;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 64;
  localparam int unsigned CNT_W       = 16;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       Sx;
  logic [1:0]       Co;
  logic             Sxe;
  logic             Coe;
  logic             exp_valid;
  logic [1:0]       exp_data;
  logic             exp_ready;
  logic             rx_valid;
  logic [1:0]       rx_data;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             illegal_err;
  logic             timeout_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rx_pulses = 0;

  qdi_result_checker #(
    .SYNC_STAGES (SYNC_STAGES),
    .FIFO_DEPTH  (4),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Sx          (Sx),
    .Co          (Co),
    .Sxe         (Sxe),
    .Coe         (Coe),
    .exp_valid   (exp_valid),
    .exp_data    (exp_data),
    .exp_ready   (exp_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .match_cnt   (match_cnt),
    .miss_cnt    (miss_cnt),
    .illegal_err (illegal_err),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rx_valid) rx_pulses <= rx_pulses + 1;
  end

  function automatic logic [1:0] dr(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  task automatic push_exp(input logic [1:0] v);
    exp_valid = 1'b1;
    exp_data  = v;
    @(negedge CLK);
    exp_valid = 1'b0;
  endtask

  task automatic wait_enables(input int unsigned limit, output bit ok);
    int unsigned n = 0;
    while (!(Sxe && Coe) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    ok = Sxe && Coe;
  endtask

  task automatic wait_acks(input int unsigned limit, output bit ok);
    int unsigned n = 0;
    while ((Sxe || Coe) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    ok = !Sxe && !Coe;
  endtask

  // Full 4-phase transfer; returns the decoded token seen on rx_data.
  task automatic send_token(input logic co, input logic sum,
                            output logic [1:0] got, output bit ok);
    bit en_ok;
    int unsigned n = 0;
    ok  = 1'b0;
    got = 2'b00;
    wait_enables(50, en_ok);
    if (!en_ok) return;
    Sx = dr(sum);
    Co = dr(co);
    do begin
      @(negedge CLK);
      n++;
    end while (!rx_valid && n < 50);
    if (rx_valid) begin
      got = rx_data;
      ok  = 1'b1;
    end
    Sx = 2'b00;
    Co = 2'b00;
  endtask

  task automatic test_reset;
    bit ok;
    RESET = 1'b1;
    Sx = 2'b00;
    Co = 2'b00;
    exp_valid = 1'b0;
    exp_data = 2'b00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    checks++;
    if (Sxe !== 1'b0 || Coe !== 1'b0) begin
      errors++;
      $display("FAIL reset_enables got Sxe=%b Coe=%b want 0 0", Sxe, Coe);
    end
    checks++;
    if (exp_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rxv=%b rxd=%b want 1 0 00", exp_ready, rx_valid, rx_data);
    end
    checks++;
    if (match_cnt !== '0 || miss_cnt !== '0 || illegal_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters got m=%0d x=%0d ill=%b to=%b want 0 0 0 0",
               match_cnt, miss_cnt, illegal_err, timeout_err);
    end
    wait_enables(SYNC_STAGES + 1, ok);
    checks++;
    if (!ok || exp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_to_wait_data got Sxe=%b Coe=%b ready=%b want 1 1 1", Sxe, Coe, exp_ready);
    end
  endtask

  task automatic test_adder;
    logic a, b, c, co, sum;
    logic [1:0] got, want;
    bit ok;
    int unsigned p0 = rx_pulses;
    for (int i = 0; i < 10; i++) begin
      a = i[0];
      b = i[1];
      c = i[2];
      want = 2'(int'(a) + int'(b) + int'(c));
      push_exp(want);
      sum = a ^ b ^ c;
      co  = (a & b) | (a & c) | (b & c);
      send_token(co, sum, got, ok);
      checks++;
      if (!ok || got !== want) begin
        errors++;
        $display("FAIL adder_token_%0d got %b (seen=%0d) want %b", i, got, ok, want);
      end
    end
    wait_enables(20, ok);
    checks++;
    if (match_cnt !== 16'd10 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL adder_counts got m=%0d x=%0d want 10 0", match_cnt, miss_cnt);
    end
    checks++;
    if (rx_pulses - p0 != 10) begin
      errors++;
      $display("FAIL adder_pulses got %0d want 10", rx_pulses - p0);
    end
  endtask

  task automatic test_mismatch;
    logic [1:0] got;
    bit ok;
    push_exp(2'b01);
    send_token(1'b1, 1'b0, got, ok);
    checks++;
    if (!ok || got !== 2'b10) begin
      errors++;
      $display("FAIL mismatch_rx_data got %b (seen=%0d) want 10", got, ok);
    end
    wait_enables(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mismatch_return got Sxe=%b Coe=%b want 1 1", Sxe, Coe);
    end
    checks++;
    if (miss_cnt !== 16'd1 || match_cnt !== 16'd10) begin
      errors++;
      $display("FAIL mismatch_counts got m=%0d x=%0d want 10 1", match_cnt, miss_cnt);
    end
  endtask

  task automatic test_empty_fifo;
    bit ok;
    bit en_low = 1'b1;
    int unsigned p0;
    Sx = 2'b10;
    Co = 2'b10;
    wait_acks(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL empty_ack got Sxe=%b Coe=%b want 0 0", Sxe, Coe);
    end
    p0 = rx_pulses;
    repeat (6) begin
      @(negedge CLK);
      if (Sxe || Coe) en_low = 1'b0;
    end
    checks++;
    if (!en_low || rx_pulses != p0) begin
      errors++;
      $display("FAIL empty_hold got enables_low=%0d pulses=%0d want 1 0", en_low, rx_pulses - p0);
    end
    exp_valid = 1'b1;
    exp_data  = 2'b11;
    @(negedge CLK);
    exp_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 2'b11) begin
      errors++;
      $display("FAIL empty_push_check got rxv=%b rxd=%b want 1 11", rx_valid, rx_data);
    end
    Sx = 2'b00;
    Co = 2'b00;
    wait_enables(20, ok);
    checks++;
    if (!ok || match_cnt !== 16'd11 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL empty_counts got m=%0d x=%0d en=%0d want 11 1 1", match_cnt, miss_cnt, ok);
    end
  endtask

  task automatic test_illegal_timeout;
    int unsigned n = 0;
    push_exp(2'b01);
    Sx = 2'b11;
    Co = 2'b01;
    do begin
      @(negedge CLK);
      n++;
    end while (!rx_valid && n < 50);
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_check got rxv=%b want 1", rx_valid);
    end
    repeat (TIMEOUT - 2) @(negedge CLK);
    checks++;
    if (illegal_err !== 1'b1 || miss_cnt !== 16'd2 || match_cnt !== 16'd11) begin
      errors++;
      $display("FAIL illegal_counts got ill=%b m=%0d x=%0d want 1 11 2", illegal_err, match_cnt, miss_cnt);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b want 0", timeout_err);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (timeout_err !== 1'b1 || Sxe !== 1'b0 || Coe !== 1'b0) begin
      errors++;
      $display("FAIL timeout_set got to=%b Sxe=%b Coe=%b want 1 0 0", timeout_err, Sxe, Coe);
    end
  endtask

  task automatic test_reset_mid_token;
    bit ok;
    bit en_low = 1'b1;
    int unsigned p0;
    push_exp(2'b00);
    Sx = 2'b10;
    Co = 2'b00;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (Sxe || Coe) en_low = 1'b0;
    end
    checks++;
    if (!en_low) begin
      errors++;
      $display("FAIL midreset_hold_init got enables_low=%0d want 1", en_low);
    end
    checks++;
    if (exp_ready !== 1'b1 || match_cnt !== '0 || miss_cnt !== '0 ||
        illegal_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got ready=%b m=%0d x=%0d ill=%b to=%b want 1 0 0 0 0",
               exp_ready, match_cnt, miss_cnt, illegal_err, timeout_err);
    end
    Sx = 2'b00;
    wait_enables(SYNC_STAGES + 2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_release got Sxe=%b Coe=%b want 1 1", Sxe, Coe);
    end
    Sx = 2'b01;
    Co = 2'b01;
    wait_acks(20, ok);
    p0 = rx_pulses;
    repeat (6) @(negedge CLK);
    checks++;
    if (!ok || rx_pulses != p0) begin
      errors++;
      $display("FAIL midreset_fifo_empty got acked=%0d pulses=%0d want 1 0", ok, rx_pulses - p0);
    end
    Sx = 2'b00;
    Co = 2'b00;
  endtask

  initial begin
    RESET     = 1'b1;
    Sx        = 2'b00;
    Co        = 2'b00;
    exp_valid = 1'b0;
    exp_data  = 2'b00;
    @(negedge CLK);
    test_reset;
    test_adder;
    test_mismatch;
    test_empty_fifo;
    test_illegal_timeout;
    test_reset_mid_token;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
